// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator: bit-growth helper, sample type
// and parameter legality check used at elaboration.
package cic_pkg;

   localparam int SAMPLE_WIDTH = 16;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

   // Full-precision gain of an M=1 interpolator is R^(N-1), i.e. this many bits.
   function automatic int cic_growth(input int n, input int r);
      return (n - 1) * $clog2(r);
   endfunction

   // N within 1..6, R a power of two and at least 2.
   function automatic bit cic_params_ok(input int n, input int r);
      return (n >= 1) && (n <= 6) && (r >= 2) && ((r & (r - 1)) == 0);
   endfunction

endpackage

// File: rtl/cic_integrator.sv
// Single CIC integrator stage: accumulates its input on every high-rate ce,
// holds otherwise. Arithmetic wraps modulo 2^W by design.
module cic_integrator
   import cic_pkg::*;
#(
   parameter int W = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce_i,
   input  logic signed [W-1:0] data_i,
   output logic signed [W-1:0] acc_o
);

   logic signed [W-1:0] acc_q;
   logic signed [W-1:0] acc_d;

   assign acc_d = acc_q + data_i;
   assign acc_o = acc_q;

   // Accumulator register, cleared asynchronously, advanced only on ce.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else if (ce_i) begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator (M=1): one-entry input buffer with valid/ready,
// comb chain at the input rate, zero-stuffing by R, and N integrators at the
// high rate. out_valid pulses one clk after each ce.
module cic_interpolator
   import cic_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int N         = 3,
   parameter int R         = 4,
   parameter int OUT_WIDTH = WIDTH + cic_growth(N, R)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ce,
   input  logic signed [WIDTH-1:0]     in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        out_valid,
   output logic                        underrun
);

   if (!cic_params_ok(N, R)) begin : g_param_check
      $error("cic_interpolator: N must be 1..6 and R a power of 2 >= 2");
   end

   localparam int PW = $clog2(R);

   logic [PW-1:0]               phase_q, phase_d;
   logic                        buf_full_q, buf_full_d;
   logic signed [WIDTH-1:0]     buf_q, buf_d;
   logic                        underrun_q, underrun_d;
   logic                        out_valid_q;
   logic signed [OUT_WIDTH-1:0] z_q, z_d;
   logic signed [OUT_WIDTH-1:0] dly_q [N];
   logic signed [OUT_WIDTH-1:0] comb  [N+1];
   logic signed [OUT_WIDTH-1:0] integ [N];
   logic signed [WIDTH-1:0]     x;
   logic                        consume;
   logic                        handshake;

   assign in_ready  = ~buf_full_q;
   assign handshake = in_valid & ~buf_full_q;
   assign consume   = ce & (phase_q == '0);

   // R is a power of two, so the phase counter wraps R-1 -> 0 on its own.
   assign phase_d = ce ? phase_q + 1'b1 : phase_q;

   // Select the source sample for a consume event and update buffer/underrun.
   always_comb begin
      x          = '0;
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
      underrun_d = underrun_q;
      if (consume) begin
         if (buf_full_q) begin
            x          = buf_q;
            buf_full_d = 1'b0;
         end else if (handshake) begin
            x = in_data;
         end else begin
            underrun_d = 1'b1;
         end
      end else if (handshake) begin
         buf_full_d = 1'b1;
         buf_d      = in_data;
      end
   end

   // Comb chain: c_0 is the sign-extended sample, c_k = c_{k-1} - d_k.
   assign comb[0] = OUT_WIDTH'(x);

   genvar gi;
   for (gi = 0; gi < N; gi++) begin : g_comb
      assign comb[gi+1] = comb[gi] - dly_q[gi];
   end

   // Zero-stuffed stream: comb result on consume, zero on the other ce cycles.
   assign z_d = consume ? comb[N] : '0;

   // Control, buffer and flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q     <= '0;
         buf_full_q  <= 1'b0;
         buf_q       <= '0;
         underrun_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         buf_full_q  <= buf_full_d;
         buf_q       <= buf_d;
         underrun_q  <= underrun_d;
         out_valid_q <= ce;
      end
   end

   // Comb delays advance only at the input rate (consume events).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            dly_q[k] <= '0;
         end
      end else if (consume) begin
         for (int k = 0; k < N; k++) begin
            dly_q[k] <= comb[k];
         end
      end
   end

   // Zero-stuff register, refreshed on every high-rate ce.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z_q <= '0;
      end else if (ce) begin
         z_q <= z_d;
      end
   end

   // Integrator cascade; each stage consumes the registered output of the previous.
   for (gi = 0; gi < N; gi++) begin : g_integ
      logic signed [OUT_WIDTH-1:0] stage_in;
      if (gi == 0) begin : g_first
         assign stage_in = z_q;
      end else begin : g_rest
         assign stage_in = integ[gi-1];
      end
      cic_integrator #(
         .W(OUT_WIDTH)
      ) u_integ (
         .clk    (clk),
         .rst    (rst),
         .ce_i   (ce),
         .data_i (stage_in),
         .acc_o  (integ[gi])
      );
   end

   assign out_data  = integ[N-1];
   assign out_valid = out_valid_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator. Expected outputs come from a
// convolution model: consumed samples, zero-stuffed by R, convolved with the
// N-fold box-filter impulse response and delayed by N ce.
module tb_cic_interpolator;
   import cic_pkg::*;

   localparam int WIDTH = 16;
   localparam int N     = 3;
   localparam int R     = 4;
   localparam int OW    = WIDTH + (N - 1) * 2;
   localparam int HL    = N * (R - 1) + 1;

   logic                 clk;
   logic                 rst;
   logic                 ce;
   sample_t              in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [OW-1:0] out_data;
   logic                 out_valid;
   logic                 underrun;

   cic_interpolator #(
      .WIDTH(WIDTH),
      .N    (N),
      .R    (R)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .underrun (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   longint            h [HL];
   longint            xs[$];
   longint            mq[$];
   int                ce_cnt;
   logic              m_underrun;
   logic signed [63:0] last_y;
   int                imp_tab[10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic build_h();
      longint tmp[HL];
      int len;
      for (int i = 0; i < HL; i++) h[i] = 0;
      h[0] = 1;
      len = 1;
      repeat (N) begin
         for (int i = 0; i < HL; i++) tmp[i] = 0;
         for (int a = 0; a < len; a++)
            for (int b = 0; b < R; b++) tmp[a+b] += h[a];
         len += R - 1;
         for (int i = 0; i < HL; i++) h[i] = tmp[i];
      end
   endtask

   function automatic logic signed [63:0] model_y(input int j);
      longint acc;
      logic signed [OW-1:0] t;
      acc = 0;
      for (int m = 0; m < xs.size(); m++) begin
         int k;
         k = j - m * R - N;
         if (k >= 0 && k < HL) acc += xs[m] * h[k];
      end
      t = acc[OW-1:0];
      return 64'(t);
   endfunction

   task automatic model_reset();
      xs.delete();
      mq.delete();
      ce_cnt     = 0;
      m_underrun = 1'b0;
      last_y     = 0;
   endtask

   // One clk: drive inputs, check readiness, advance model, check outputs.
   task automatic tick(input logic ce_v, input logic vld_v, input sample_t dat_v);
      logic exp_ready;
      logic hs;
      ce       = ce_v;
      in_valid = vld_v;
      in_data  = dat_v;
      #1;
      exp_ready = (mq.size() == 0);
      check("in_ready", in_ready, exp_ready);
      hs = vld_v & exp_ready;
      if (ce_v && (ce_cnt % R == 0)) begin
         if (mq.size() != 0) xs.push_back(mq.pop_front());
         else if (hs) xs.push_back(longint'(dat_v));
         else begin
            xs.push_back(0);
            m_underrun = 1'b1;
         end
      end else if (hs) begin
         mq.push_back(longint'(dat_v));
      end
      @(posedge clk);
      #1;
      if (ce_v) begin
         last_y = model_y(ce_cnt);
         ce_cnt++;
      end
      check("out_valid", out_valid, ce_v);
      check("out_data", out_data, last_y);
      check("underrun", underrun, m_underrun);
   endtask

   task automatic do_reset();
      ce = 1'b0; in_valid = 1'b0; in_data = '0;
      rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   // Impulse (1 then zeros) with ce every `gap` clks, checked against the table.
   task automatic impulse_run(input int gap, input string tag);
      for (int i = 0; i < 20 * gap; i++) begin
         logic cev;
         cev = (i % gap == 0);
         tick(cev, 1'b1, (i == 0) ? sample_t'(1) : sample_t'(0));
         if (cev) begin
            int j;
            j = ce_cnt - 1;
            if (j >= N && j - N < 10) check(tag, out_data, imp_tab[j-N]);
            else check(tag, out_data, 0);
         end
      end
   endtask

   initial begin
      ce = 1'b0; in_valid = 1'b0; in_data = '0;
      rst = 1'b1;
      build_h();
      model_reset();
      #2;
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_underrun", underrun, 0);
      do_reset();

      // Impulse, dense ce
      impulse_run(1, "impulse_dense");

      // Impulse, sparse ce (every 3rd clk)
      do_reset();
      impulse_run(3, "impulse_sparse");

      // DC positive
      do_reset();
      for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, sample_t'(1000));
      check("dc_pos", out_data, 16000);

      // DC negative full scale
      do_reset();
      for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, sample_t'(-32768));
      check("dc_neg", out_data, -524288);

      // Underrun: withhold data across the first consume, then resume
      do_reset();
      tick(1'b1, 1'b0, sample_t'(0));
      check("underrun_set", underrun, 1);
      tick(1'b1, 1'b1, sample_t'(5));
      for (int i = 0; i < 24; i++) tick(1'b1, 1'b1, sample_t'(0));
      check("underrun_sticky", underrun, 1);

      // Async reset during the integrator ramp, then impulse again
      do_reset();
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, (i == 0) ? sample_t'(1) : sample_t'(0));
      rst = 1'b0;
      #1;
      check("arst_out_data", out_data, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_underrun", underrun, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      impulse_run(1, "impulse_after_rst");

      // Randomized traffic: random ce, valid and full-range data
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic cev;
         logic vld;
         cev = ($urandom_range(0, 2) != 0);
         vld = ($urandom_range(0, 4) != 0);
         tick(cev, vld, sample_t'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
